// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control FSM states and the hardwired-zero register index.
package pipeline_pkg;

   typedef enum logic {S_RUN, S_MUL} ctrl_state_t;

   localparam logic [4:0] REG_ZERO = 5'h00;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter; increments when inc is high and sticks at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}}))
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: load-use bubble, branch squash and multi-cycle Execute hold.
// Outputs are same-cycle (Mealy) decodes of the current inputs and state, forced low during reset.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             LoadE,
   input  logic [4:0]       RDE,
   input  logic [4:0]       RS1D,
   input  logic [4:0]       RS2D,
   input  logic             PCSrcE,
   input  logic             MulStartE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushM,
   output logic             MulDoneE,
   output logic             Busy,
   output logic [CNT_W-1:0] StallCount
);

   localparam int CW = $clog2(MUL_LAT);
   // The accept cycle is the first stall cycle, so the counter starts two below the latency.
   localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 2);

   ctrl_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load_use;
   logic          hold, bubble, squash, done;

   assign load_use = LoadE && (RDE != REG_ZERO) && ((RDE == RS1D) || (RDE == RS2D));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold    = 1'b0;
      bubble  = 1'b0;
      squash  = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_RUN: begin
            if (MulStartE) begin
               hold    = 1'b1;
               cnt_d   = CNT_INIT;
               state_d = S_MUL;
            end else if (PCSrcE) begin
               squash = 1'b1;
            end else if (load_use) begin
               bubble = 1'b1;
            end
         end
         S_MUL: begin
            if (cnt_q != '0) begin
               hold  = 1'b1;
               cnt_d = cnt_q - 1'b1;
            end else begin
               done    = 1'b1;
               state_d = S_RUN;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign StallF   = !reset && (hold || bubble);
   assign StallD   = !reset && (hold || bubble);
   assign StallE   = !reset && hold;
   assign FlushM   = !reset && hold;
   assign FlushD   = !reset && squash;
   assign FlushE   = !reset && (squash || bubble);
   assign MulDoneE = !reset && done;
   assign Busy     = !reset && (state_q == S_MUL);

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (StallF),
      .count (StallCount)
   );

   a_mul_load:   assert property (@(posedge clk) disable iff (reset) !(MulStartE && LoadE));
   a_mul_branch: assert property (@(posedge clk) disable iff (reset) !(MulStartE && PCSrcE));

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Stall/flush sequencer for the 5-stage RISC-V pipeline; covers the hazards the forwarding unit cannot resolve. It generates:
- a one-cycle load-use bubble;
- D/E flushes for taken branches/jumps resolved in Execute;
- a multi-cycle hold while an iterative multiply/divide unit occupies Execute.

It also keeps a saturating stall-cycle counter for performance readout. It sits beside the forwarding unit and drives the enable/clear pins of the F/D, D/E and E/M pipeline registers.

## Interface
- MUL_LAT, 4, total cycles a multi-cycle op occupies Execute (legal ≥ 2)
- CNT_W, 16, width of stall counter
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- LoadE  input  1  instruction in Execute is a load
- RDE  input  5  destination register of instruction in Execute
- RS1D, RS2D  input  5  source registers of instruction in Decode
- PCSrcE  input  1  taken branch/jump resolved in Execute
- MulStartE  input  1  instruction in Execute is a multi-cycle MUL/DIV
- StallF, StallD, StallE  output  1  hold PC / F-D / D-E registers
- FlushD, FlushE, FlushM  output  1  clear F-D / D-E / E-M registers to bubble
- MulDoneE  output  1  multi-cycle result valid this cycle; Execute advances
- Busy  output  1  FSM in S_MUL
- StallCount  output  CNT_W  cycles with StallF=1, saturating

## Operation
- FSM states:
  - S_RUN (reset state);
  - S_MUL, with down-counter cnt (width clog2(MUL_LAT)).
- Load-use hazard: LoadE && RDE≠0 && (RDE==RS1D || RDE==RS2D).
- S_RUN, evaluated in this priority order (all Mealy, same cycle):
  1. MulStartE=1: StallF=StallD=StallE=1, FlushM=1. cnt←MUL_LAT-2, next S_MUL. PCSrcE and load-use are ignored.
  2. PCSrcE=1: FlushD=FlushE=1, no stalls. A load-use in the same cycle is ignored, because the Decode instruction is being squashed.
  3. Load-use hazard: StallF=StallD=1, FlushE=1. This lasts one cycle by construction, since LoadE=0 after the bubble.
  4. Otherwise all outputs 0.
- S_MUL:
  - cnt≠0: StallF=StallD=StallE=1, FlushM=1, cnt←cnt-1.
  - cnt==0: all stalls/flushes 0, MulDoneE=1, next S_RUN.
  - PCSrcE, LoadE and MulStartE are ignored throughout S_MUL; MulStartE is still high during the done cycle.
- FlushM equals StallE in every cycle.
- StallCount increments on every cycle with StallF=1 and holds at 2^CNT_W-1.
- Illegal combinations, flagged by simulation-only assertions:
  - MulStartE && LoadE;
  - MulStartE && PCSrcE.

## Timing
- Reset values: state=S_RUN, cnt=0, StallCount=0. All outputs 0 while reset is high.
- Reset mid-S_MUL aborts the operation; no MulDoneE is produced.
- Load-use stall: asserted in the detection cycle, deasserted in the next.
- Branch flush: asserted in the cycle PCSrcE=1 only.
- Multi-cycle op accepted at cycle t:
  - stalls high for cycles t … t+MUL_LAT-2 (MUL_LAT-1 cycles);
  - MulDoneE high at t+MUL_LAT-1;
  - back in S_RUN at t+MUL_LAT.
- MUL_LAT=2: a single S_MUL cycle, which is the done cycle.
- Back-to-back multi-cycle ops: a new MulStartE seen in S_RUN at t+MUL_LAT is accepted normally, with no idle gap required.

## Structure
- Shared package pipeline_pkg holds:
  - state enum ctrl_state_t {S_RUN, S_MUL};
  - the REG_ZERO = 5'h00 constant used by both this block and the forwarding unit.
- One natural sub-module: sat_counter (parameter CNT_W; ports inc, count) for StallCount. The FSM and hazard compare stay in pipeline_ctrl.

## Test plan
- Load-use: LoadE=1, RDE=5, RS1D=5 for one cycle → StallF=StallD=FlushE=1 that cycle, all 0 next; StallCount=1. Same with RDE=0 → no stall.
- Branch + load-use together: PCSrcE=1, LoadE=1, RDE=RS2D=7 → FlushD=FlushE=1, StallF=0, StallCount unchanged.
- Multi-cycle, MUL_LAT=4: MulStartE held high from t → StallE/FlushM=1 at t, t+1, t+2; MulDoneE=1 and stalls 0 at t+3; Busy=1 at t+1..t+3; StallCount=3.
- MUL_LAT=2 and back-to-back ops: two consecutive ops → stalls at t and t+2, MulDoneE at t+1 and t+3.
- Reset mid-op: assert reset at t+1 of a MUL_LAT=4 op → all outputs 0 immediately, state S_RUN, no MulDoneE, StallCount=0.
- Saturation: CNT_W=4, hold a stall condition for 20 cycles → StallCount stops at 15.
